// File: rtl/cep_uart_receiver.sv
// -----------------------------------------------------------------------------
// cep_uart_receiver
//
// 8N1 UART receiver for the CEP link. The serial line is synchronised, then
// oversampled at 16x the baud rate using a tick generator that is re-aligned
// to every start edge. The start bit is qualified at mid-bit, each data bit is
// sampled at mid-bit (LSB first), and the stop bit is checked at mid-bit.
//
// Parameters:
//   CLK_FREQ     system clock frequency in Hz
//   BAUD         line rate in bit/s (DIV = CLK_FREQ/(BAUD*16), must be >= 2)
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous active-high reset
//   serial_in    asynchronous serial line, idle high
//   data_out     last byte received with a valid stop bit
//   valid_out    one-cycle pulse, data_out updated this cycle
//   frame_error  one-cycle pulse, stop bit sampled low
//   busy         high while a frame is in progress
// -----------------------------------------------------------------------------
module cep_uart_receiver #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_error,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      sample_cnt_q, sample_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser resets to the idle line level so a reset never looks
      // like a start edge.
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      rx_meta_q    <= serial_in;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + CW'(1);
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Falling edge on the synchronised line: realign the tick phase to
        // the edge so mid-bit sampling is centred.
        if (rx_prev_q && !rx_s_q) begin
          tick_cnt_d   = '0;
          sample_cnt_d = '0;
          state_d      = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (sample_cnt_q == 4'd7) begin
            // Mid start bit: a high line here was a glitch.
            if (!rx_s_q) begin
              sample_cnt_d = '0;
              bit_cnt_d    = '0;
              state_d      = S_DATA;
            end else begin
              state_d      = S_IDLE;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (sample_cnt_q == 4'd15) begin
            // LSB arrives first, so shifting in from the MSB side leaves the
            // byte in natural order after eight bits.
            shift_d      = {rx_s_q, shift_q[7:1]};
            sample_cnt_d = '0;
            bit_cnt_d    = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (sample_cnt_q == 4'd15) begin
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d  = 1'b1;
            end
            // Leaving at mid-stop lets a zero-gap next start edge be caught.
            state_d = S_IDLE;
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != S_IDLE);

endmodule
